rng_arbiter: RTL and testbench
==============================

Name: rng_arbiter

Overview:
- Shares one pulse-stepped LFSR random generator between NUM_REQ game-logic requesters (ball kick direction, keeper dive, AI choices).
- Each requester raises a level request with its own upper bound. The block grants requesters round-robin and drives the generator's enable and max inputs.
- Steps the generator exactly once per grant, captures the clamped value and returns it with a one-cycle valid/ack pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, random value and max width; matches the generator
- CNT_W, 16, width of the draw counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NUM_REQ  level request per requester; held until its ack
- req_max  in  NUM_REQ*WIDTH  per-requester bound; slice i = bits [i*WIDTH +: WIDTH]
- rng_enable  out  1  step pulse to the generator, which advances on enable rising edge
- rng_max  out  WIDTH  bound to the generator (req_max slice of the granted requester)
- rng_value  in  WIDTH  generator output, already clamped to rng_max
- ack  out  NUM_REQ  one-hot, one-cycle pulse to the served requester
- rsp_valid  out  1  one-cycle pulse, coincident with ack
- rsp_id  out  $clog2(NUM_REQ)  index of the served requester
- rsp_data  out  WIDTH  captured random value; holds until the next capture
- busy  out  1  high in any state other than IDLE
- draw_count  out  CNT_W  number of completed draws; wraps modulo 2^CNT_W

Behaviour:
- Reset values: FSM=IDLE, rng_enable=0, rng_max=0, ack=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, draw_count=0, rr pointer=0.
- FSM states: IDLE -> PULSE -> SETTLE -> DELIVER -> IDLE.
- IDLE:
  - If any req bit is high, select the first set bit searching from the rr pointer upward, wrapping at NUM_REQ-1.
  - Register the selected index as gnt_id and its req_max slice as rng_max; go to PULSE.
  - If no req bit is high, stay in IDLE.
- PULSE: rng_enable=1 for exactly this cycle; go to SETTLE.
- SETTLE:
  - rng_enable=0. This low cycle is mandatory so the generator's edge detector re-arms before the next pulse.
  - At the end of the cycle, register rsp_data<=rng_value; go to DELIVER.
- DELIVER:
  - rsp_valid=1, ack[gnt_id]=1, rsp_id=gnt_id.
  - draw_count increments; rr pointer <= (gnt_id+1) mod NUM_REQ; go to IDLE.
- Latency: request sampled in IDLE at cycle T -> rsp_valid at cycle T+3.
- Throughput: one draw per 4 cycles with requests continuously pending.
- rng_enable is registered (glitch-free) and is never high in two consecutive cycles.
- rng_max is registered in IDLE and held stable through PULSE, SETTLE and DELIVER. It changes only on the next grant.
- Requester contract: drop req in the cycle after ack. The following IDLE therefore does not re-grant the same pulse.
  - A requester that keeps req high is served again, but only when round-robin order reaches it.
- Request withdrawn after grant: the draw still completes and ack/rsp_valid still pulse; there is no cancel.
- req bits changing during PULSE/SETTLE/DELIVER are ignored until the next IDLE.
- Simultaneous requests: strict round-robin. With all NUM_REQ pending, every requester is served once per NUM_REQ grants.
- req_max slice = 0: the value passes through unchanged (the generator returns 0). No special case.
- draw_count wraps from 2^CNT_W-1 to 0 without saturation.
- Asynchronous reset mid-operation: immediately forces the reset values.
  - The in-flight draw is lost with no ack.
  - The generator may or may not have advanced; the arbiter does not track this.

Test Plan:
- Bench instantiates the real generator (seed 0x4c93).
- Single requester: req=4'b0001, req_max[0]=0xFFFFFFFF at cycle T.
  - Expect rng_enable high at T+1 only.
  - Expect rsp_valid, ack=0001, rsp_id=0, rsp_data=0x00009926 at T+3.
  - Expect busy high T+1..T+3 and draw_count=1.
- Clamping: same as above but req_max[0]=5 -> rsp_data=5. A second request with max 0xFFFFFFFF -> rsp_data=0x0001324D.
- Round-robin with all four requesting and holding until ack:
  - Expect ack order 0001, 0010, 0100, 1000, 0001.
  - Expect acks spaced exactly 4 cycles apart.
  - Expect rng_enable never high on adjacent cycles.
- Pointer fairness: serve requester 2, then raise req=4'b0101 -> requester 0 is served next (pointer=3 wraps to 0). Next grant goes to requester 2.
- Withdrawal and max stability:
  - Requester 1 drops req during SETTLE -> ack[1] still pulses and draw_count increments.
  - Changing req_max[1] during PULSE does not alter rng_max.
- Reset mid-operation: assert reset during SETTLE -> all outputs 0 and busy low immediately; no ack. After release with req pending, a normal 3-cycle grant follows.

Source files
------------

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one pulse-stepped LFSR generator between NUM_REQ requesters.
// Each grant steps the generator once, captures the clamped value and returns it with a valid/ack pulse.
module rng_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_max_i,
    output logic                     rng_enable_o,
    output logic [WIDTH-1:0]         rng_max_o,
    input  logic [WIDTH-1:0]         rng_value_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     rsp_valid_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         draw_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        SETTLE  = 2'd2,
        DELIVER = 2'd3
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_q;
    logic               rng_enable_q;
    logic [WIDTH-1:0]   rng_max_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               busy_q;
    logic [CNT_W-1:0]   draw_count_q;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    cand;
    logic [WIDTH-1:0]   pick_max;

    // First pending request at or above the rr pointer, wrapping at NUM_REQ-1.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        pick_max = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_max = req_max_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // SETTLE keeps enable low one cycle so the generator's edge detector re-arms.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rng_enable_q <= 1'b0;
            rng_max_q    <= '0;
            ack_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            draw_count_q <= '0;
        end else begin
            rng_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ack_q        <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q        <= pick_id;
                        rng_max_q    <= pick_max;
                        rng_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= PULSE;
                    end
                end
                PULSE: begin
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    rsp_data_q   <= rng_value_i;
                    rsp_valid_q  <= 1'b1;
                    ack_q        <= NUM_REQ'(1) << gnt_q;
                    rsp_id_q     <= gnt_q;
                    draw_count_q <= draw_count_q + CNT_W'(1);
                    state_q      <= DELIVER;
                end
                DELIVER: begin
                    ptr_q   <= (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rng_enable_o = rng_enable_q;
    assign rng_max_o    = rng_max_q;
    assign ack_o        = ack_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign busy_o       = busy_q;
    assign draw_count_o = draw_count_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: drives directed requests against a pulse-stepped LFSR generator
// and checks every cycle against a transaction-level timeline model.
module tb_rng_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 3;
    localparam int unsigned ID_W = 2;
    localparam logic [31:0] SEED = 32'h0000_4c93;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [W-1:0]    mx [N];
    logic [N*W-1:0]  req_max;
    logic            rng_enable;
    logic [W-1:0]    rng_max;
    logic [W-1:0]    rng_value;
    logic [N-1:0]    ack;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]    rsp_data;
    logic            busy;
    logic [CW-1:0]   draw_count;

    assign req_max = {mx[3], mx[2], mx[1], mx[0]};

    rng_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .req_i        (req),
        .req_max_i    (req_max),
        .rng_enable_o (rng_enable),
        .rng_max_o    (rng_max),
        .rng_value_i  (rng_value),
        .ack_o        (ack),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .draw_count_o (draw_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Generator: advances on a rising edge of enable, output clamped to max.
    logic [31:0] gen_q    = SEED;
    logic        gen_prev = 1'b0;
    logic        reseed   = 1'b0;
    always @(posedge clk) begin
        gen_prev <= rng_enable;
        if (reseed) gen_q <= SEED;
        else if (rng_enable && !gen_prev) gen_q <= lfsr_step(gen_q);
    end
    assign rng_value = (gen_q > rng_max) ? rng_max : gen_q;

    // Model: a grant at cycle T is fully described by (T, id, max, data, count).
    int          gc     = -100;
    int          g_id   = 0;
    int          g_cnt  = 0;
    int          o_cnt  = 0;
    int          m_ptr  = 0;
    int          m_id   = 0;
    logic [31:0] g_max  = '0;
    logic [31:0] o_max  = '0;
    logic [31:0] g_data = '0;
    logic [31:0] o_data = '0;
    logic [31:0] m_lfsr = SEED;
    logic [N-1:0] m_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gc = -100; g_id = 0; g_cnt = 0; o_cnt = 0; m_ptr = 0;
            g_max = '0; o_max = '0; g_data = '0; o_data = '0;
        end else begin
            if (reseed) m_lfsr = SEED;
            m_req = req;
            if (cyc >= gc + 4 && m_req != '0) begin
                m_id = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_id < 0 && m_req[ID_W'((m_ptr + k) % N)]) m_id = (m_ptr + k) % N;
                end
                o_max  = g_max;
                o_data = g_data;
                o_cnt  = g_cnt;
                g_id   = m_id;
                g_max  = mx[ID_W'(m_id)];
                m_lfsr = lfsr_step(m_lfsr);
                g_data = (m_lfsr > g_max) ? g_max : m_lfsr;
                g_cnt  = (o_cnt + 1) % (1 << CW);
                m_ptr  = (m_id + 1) % N;
                gc     = cyc;
            end
        end
    end

    logic prev_en = 1'b0;
    int   en_cyc  = -1;
    always @(negedge clk) begin : cmp
        int c;
        logic [3:0] e_ack;
        c = cyc;
        e_ack = (c == gc + 3) ? 4'(4'b0001 << g_id) : 4'b0000;
        check("rng_enable", 64'(rng_enable), 64'(c == gc + 1));
        check("busy", 64'(busy), 64'(c >= gc + 1 && c <= gc + 3));
        check("rsp_valid", 64'(rsp_valid), 64'(c == gc + 3));
        check("ack", 64'(ack), 64'(e_ack));
        check("rng_max", 64'(rng_max), 64'((c >= gc + 1) ? g_max : o_max));
        check("rsp_data", 64'(rsp_data), 64'((c >= gc + 3) ? g_data : o_data));
        check("draw_count", 64'(draw_count), 64'((c >= gc + 3) ? g_cnt : o_cnt));
        if (c == gc + 3) check("rsp_id", 64'(rsp_id), 64'(g_id));
        check("en_adjacent", 64'(rng_enable & prev_en), 64'd0);
        if (rng_enable) en_cyc = c;
        prev_en = rng_enable;
    end

    task automatic wait_valid(input int bound, output bit got, output int at, output logic [3:0] a);
        got = 1'b0; at = -1; a = '0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; at = cyc; a = ack;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: no rsp_valid within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    // One requester alone: checks latency, enable timing, ack and optionally data.
    task automatic serve(input logic [1:0] id, input logic [31:0] m,
                         input bit chk_data, input logic [31:0] exp_data);
        bit got; int at; int t0; logic [3:0] a;
        @(posedge clk); #1;
        mx[id] = m;
        req[id] = 1'b1;
        t0 = cyc;
        wait_valid(10, got, at, a);
        check("serve latency", 64'(at - t0), 64'd3);
        check("serve enable cycle", 64'(en_cyc), 64'(t0 + 1));
        check("serve ack", 64'(a), 64'(4'(4'b0001 << id)));
        check("serve rsp_id", 64'(rsp_id), 64'(id));
        if (chk_data) check("serve rsp_data", 64'(rsp_data), 64'(exp_data));
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    initial begin
        bit got; int at; int t0; logic [3:0] a;
        logic [3:0] rr_ack [5];
        int rr_at [5];
        logic [3:0] rr_exp [5];
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int i = 0; i < N; i++) mx[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset draw_count", 64'(draw_count), 64'd0);
        check("reset rng_max", 64'(rng_max), 64'd0);

        serve(2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0000_9926);
        check("first draw_count", 64'(draw_count), 64'd1);

        @(posedge clk); #1 reseed = 1'b1;
        @(posedge clk); #1 reseed = 1'b0;
        serve(2'd0, 32'd5, 1'b1, 32'd5);
        serve(2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0001_324D);
        check("clamp draw_count", 64'(draw_count), 64'd3);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < N; i++) mx[i] = 32'hFFFF_FFFF;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_valid(10, got, at, a);
            rr_ack[i] = a;
            rr_at[i]  = at;
        end
        @(posedge clk); #1 req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("rr ack order", 64'(rr_ack[i]), 64'(rr_exp[i]));
            if (i > 0) check("rr spacing", 64'(rr_at[i] - rr_at[i-1]), 64'd4);
        end
        check("rr draw_count", 64'(draw_count), 64'd5);

        serve(2'd2, 32'h0000_FFFF, 1'b0, 32'd0);
        @(posedge clk); #1 req = 4'b0101;
        wait_valid(10, got, at, a);
        check("wrap grant to 0", 64'(a), 64'(4'b0001));
        wait_valid(10, got, at, a);
        check("next grant to 2", 64'(a), 64'(4'b0100));
        @(posedge clk); #1 req = 4'b0000;
        check("draw_count wrap", 64'(draw_count), 64'd0);

        @(posedge clk); #1;
        mx[1] = 32'h0000_1234;
        req   = 4'b0010;
        t0    = cyc;
        @(posedge clk); #1;
        mx[1] = 32'hFFFF_0000;
        check("max at pulse", 64'(rng_max), 64'h1234);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_valid(10, got, at, a);
        check("withdraw latency", 64'(at - t0), 64'd3);
        check("withdraw ack", 64'(a), 64'(4'b0010));
        check("withdraw max held", 64'(rng_max), 64'h1234);
        check("withdraw draw_count", 64'(draw_count), 64'd1);

        @(posedge clk); #1;
        mx[3] = 32'hFFFF_FFFF;
        req   = 4'b1000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("settle busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst rng_enable", 64'(rng_enable), 64'd0);
        check("rst ack", 64'(ack), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst draw_count", 64'(draw_count), 64'd0);
        check("rst rsp_data", 64'(rsp_data), 64'd0);
        check("rst rng_max", 64'(rng_max), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        t0  = cyc;
        wait_valid(10, got, at, a);
        check("post-reset latency", 64'(at - t0), 64'd3);
        check("post-reset ack", 64'(a), 64'(4'b1000));
        @(posedge clk); #1 req = 4'b0000;

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
